// File: rtl/basic_gates_pkg.sv
// Shared gate definitions for the basic_gates bank: gate indices and the
// single-bit gate function used by the core and by anyone modelling it.
package gates_pkg;

  localparam int NUM_GATES  = 8;
  localparam int GATE_IDX_W = 3;

  typedef logic [GATE_IDX_W-1:0] gate_idx_t;

  localparam gate_idx_t G_AND  = 3'd0;
  localparam gate_idx_t G_OR   = 3'd1;
  localparam gate_idx_t G_NOTA = 3'd2;
  localparam gate_idx_t G_NOTB = 3'd3;
  localparam gate_idx_t G_NAND = 3'd4;
  localparam gate_idx_t G_NOR  = 3'd5;
  localparam gate_idx_t G_XOR  = 3'd6;
  localparam gate_idx_t G_XNOR = 3'd7;

  // Plain operators only, so X/Z on a or b propagate with normal semantics.
  function automatic logic gate_eval(input gate_idx_t idx, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (idx)
      G_AND:  r = a & b;
      G_OR:   r = a | b;
      G_NOTA: r = ~a;
      G_NOTB: r = ~b;
      G_NAND: r = ~(a & b);
      G_NOR:  r = ~(a | b);
      G_XOR:  r = a ^ b;
      G_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/basic_gates_if.sv
// Operand/result bundle for the basic_gates bank; master drives operands,
// slave (the gate bank) drives the eight results.
interface basic_gates_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out_and;
  logic [WIDTH-1:0] out_or;
  logic [WIDTH-1:0] out_nota;
  logic [WIDTH-1:0] out_notb;
  logic [WIDTH-1:0] out_nand;
  logic [WIDTH-1:0] out_nor;
  logic [WIDTH-1:0] out_xor;
  logic [WIDTH-1:0] out_xnor;

  modport master (
    output a, b,
    input  out_and, out_or, out_nota, out_notb,
    input  out_nand, out_nor, out_xor, out_xnor
  );

  modport slave (
    input  a, b,
    output out_and, out_or, out_nota, out_notb,
    output out_nand, out_nor, out_xor, out_xnor
  );
endinterface

// File: rtl/basic_gates_core.sv
// Combinational core: all eight gates applied bit-wise, bit i of every result
// depending only on a[i] and b[i].
module gate_core
  import gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  output logic [NUM_GATES-1:0][WIDTH-1:0]  res
);

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign res[g][i] = gate_eval(gate_idx_t'(g), a[i], b[i]);
    end
  end

endmodule

// File: rtl/basic_gates.sv
// Bit-wise two-input gate bank with optional one-cycle output register
// (OUT_REG=1) or a pure combinational path (OUT_REG=0).
module basic_gates
  import gates_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  basic_gates_if.slave bus
);

  logic [NUM_GATES-1:0][WIDTH-1:0] res;
  logic [NUM_GATES-1:0][WIDTH-1:0] res_q;

  gate_core #(.WIDTH(WIDTH)) u_core (
    .a   (bus.a),
    .b   (bus.b),
    .res (res)
  );

  if (OUT_REG) begin : g_reg
    // NOTE: every result register clears to zero, including the inverting
    // gates, so reset is visible as all-zeros rather than as a gate result.
    // NOTE: non-blocking assignment keeps flop updates order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_q <= '0;
      else        res_q <= res;
    end
  end else begin : g_comb
    assign res_q = res;
    // Clock and reset have no function on the combinational path.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

  assign bus.out_and  = res_q[G_AND];
  assign bus.out_or   = res_q[G_OR];
  assign bus.out_nota = res_q[G_NOTA];
  assign bus.out_notb = res_q[G_NOTB];
  assign bus.out_nand = res_q[G_NAND];
  assign bus.out_nor  = res_q[G_NOR];
  assign bus.out_xor  = res_q[G_XOR];
  assign bus.out_xnor = res_q[G_XNOR];

endmodule

// File: tb/tb_basic_gates.sv
// Directed bench for basic_gates: registered 1-bit and 8-bit instances plus a
// combinational 1-bit instance, checked against hand-computed truth tables.
module tb_basic_gates;

  logic clk;
  logic rst_n;

  basic_gates_if #(.WIDTH(1)) if1 ();
  basic_gates_if #(.WIDTH(8)) if8 ();
  basic_gates_if #(.WIDTH(1)) ifc ();

  basic_gates #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  basic_gates #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  basic_gates #(.WIDTH(1), .OUT_REG(1'b0)) u_c  (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Packed {and, or, nota, notb, nand, nor, xor, xnor}
  function automatic logic [7:0] vec_w1();
    return {if1.out_and, if1.out_or, if1.out_nota, if1.out_notb,
            if1.out_nand, if1.out_nor, if1.out_xor, if1.out_xnor};
  endfunction

  function automatic logic [7:0] vec_c();
    return {ifc.out_and, ifc.out_or, ifc.out_nota, ifc.out_notb,
            ifc.out_nand, ifc.out_nor, ifc.out_xor, ifc.out_xnor};
  endfunction

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] exp;
  } row_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_and, e_or, e_nota, e_notb, e_nand, e_nor, e_xor, e_xnor;
  } wide_t;

  row_t  tbl[4];
  wide_t wtbl[2];

  initial begin
    tbl[0] = '{a: 1'b0, b: 1'b0, exp: 8'b0011_1101};
    tbl[1] = '{a: 1'b0, b: 1'b1, exp: 8'b0110_1010};
    tbl[2] = '{a: 1'b1, b: 1'b0, exp: 8'b0101_1010};
    tbl[3] = '{a: 1'b1, b: 1'b1, exp: 8'b1100_0001};

    wtbl[0] = '{a: 8'hF0, b: 8'hCC, e_and: 8'hC0, e_or: 8'hFC, e_nota: 8'h0F, e_notb: 8'h33,
                e_nand: 8'h3F, e_nor: 8'h03, e_xor: 8'h3C, e_xnor: 8'hC3};
    wtbl[1] = '{a: 8'h5A, b: 8'h0F, e_and: 8'h0A, e_or: 8'h5F, e_nota: 8'hA5, e_notb: 8'hF0,
                e_nand: 8'hF5, e_nor: 8'hA0, e_xor: 8'h55, e_xnor: 8'hAA};

    // Reset held with all-ones operands: registered outputs all zero, no edge needed
    rst_n = 1'b0;
    if1.a = 1'b1;  if1.b = 1'b1;
    if8.a = 8'hFF; if8.b = 8'hFF;
    ifc.a = 1'b0;  ifc.b = 1'b1;
    #1;
    check("reset_w1_no_edge", vec_w1(), 8'h00);
    check("reset_w8_and", if8.out_and, 8'h00);
    check("reset_w8_xnor", if8.out_xnor, 8'h00);
    check("reset_w8_nand", if8.out_nand, 8'h00);
    check("comb_in_reset", vec_c(), tbl[1].exp);
    repeat (2) @(posedge clk);
    #1;
    check("reset_w1_held", vec_w1(), 8'h00);
    check("reset_w8_nor_held", if8.out_nor, 8'h00);

    // Exhaustive 1-bit rows on successive edges, starting on the first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if1.a = tbl[i].a;
      if1.b = tbl[i].b;
      #1;
      check($sformatf("row%0d_before_edge", i), vec_w1(), (i == 0) ? 8'h00 : tbl[i-1].exp);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_after_edge", i), vec_w1(), tbl[i].exp);
    end

    // Latency: xor tracks the operands sampled one edge earlier
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b0;
    @(posedge clk);
    #1;
    check("latency_xor_1", {7'd0, if1.out_xor}, 8'h01);
    @(negedge clk);
    if1.a = 1'b0; if1.b = 1'b0;
    #1;
    check("latency_xor_hold", {7'd0, if1.out_xor}, 8'h01);
    @(posedge clk);
    #1;
    check("latency_xor_0", {7'd0, if1.out_xor}, 8'h00);

    // Mid-run reset pulse between edges
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_loaded_and", {7'd0, if1.out_and}, 8'h01);
    check("midrst_loaded_xnor", {7'd0, if1.out_xnor}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_and", {7'd0, if1.out_and}, 8'h00);
    check("midrst_async_xnor", {7'd0, if1.out_xnor}, 8'h00);
    @(posedge clk);
    #1;
    check("midrst_held_edge", vec_w1(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_reload_and", {7'd0, if1.out_and}, 8'h01);
    check("midrst_reload_xnor", {7'd0, if1.out_xnor}, 8'h01);

    // 8-bit vectors: every gate bit-wise, plus complement invariants
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if8.a = wtbl[i].a;
      if8.b = wtbl[i].b;
      @(posedge clk);
      #1;
      check($sformatf("w8_%0d_and", i),  if8.out_and,  wtbl[i].e_and);
      check($sformatf("w8_%0d_or", i),   if8.out_or,   wtbl[i].e_or);
      check($sformatf("w8_%0d_nota", i), if8.out_nota, wtbl[i].e_nota);
      check($sformatf("w8_%0d_notb", i), if8.out_notb, wtbl[i].e_notb);
      check($sformatf("w8_%0d_nand", i), if8.out_nand, wtbl[i].e_nand);
      check($sformatf("w8_%0d_nor", i),  if8.out_nor,  wtbl[i].e_nor);
      check($sformatf("w8_%0d_xor", i),  if8.out_xor,  wtbl[i].e_xor);
      check($sformatf("w8_%0d_xnor", i), if8.out_xnor, wtbl[i].e_xnor);
      check($sformatf("w8_%0d_inv_nand", i), if8.out_nand, ~if8.out_and);
      check($sformatf("w8_%0d_inv_xnor", i), if8.out_xnor, ~if8.out_xor);
    end

    // Combinational instance: zero latency, reset irrelevant, changes mid-cycle
    #2;
    ifc.a = 1'b0; ifc.b = 1'b1;
    #1;
    check("comb_01_or_nota_xor",
          {5'd0, ifc.out_or, ifc.out_nota, ifc.out_xor}, 8'b0000_0111);
    for (int i = 0; i < 4; i++) begin
      ifc.a = tbl[i].a;
      ifc.b = tbl[i].b;
      #1;
      check($sformatf("comb_row%0d", i), vec_c(), tbl[i].exp);
    end
    rst_n = 1'b0;
    ifc.a = 1'b1; ifc.b = 1'b0;
    #1;
    check("comb_row2_in_reset", vec_c(), tbl[2].exp);
    rst_n = 1'b1;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
